// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 ALU controller: ALU op encoding,
// ALU_Op classes, M-extension funct3 codes and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } md_state_e;

    // MULH/MULHSU/DIV/REM read rs1 as signed; only MULH/DIV/REM read rs2 as signed.
    function automatic logic signedRs1(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signedRs2(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply, or
// restoring divide when ALU_CTRL_DIV_EN is defined. One step per run_i cycle.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef ALU_CTRL_DIV_EN
    input  logic            isDiv_i,
`endif
    input  logic            start_i,
    input  logic            run_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   sum;
`ifdef ALU_CTRL_DIV_EN
    logic            isDiv_q;
    logic [XLEN:0]   shifted, diff;
`endif

    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_CTRL_DIV_EN
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        if (isDiv_q) begin
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef ALU_CTRL_DIV_EN
            isDiv_q <= 1'b0;
`endif
        end else if (start_i) begin
            hi_q    <= '0;
            lo_q    <= a_i;
            b_q     <= b_i;
            cnt_q   <= '0;
`ifdef ALU_CTRL_DIV_EN
            isDiv_q <= isDiv_i;
`endif
        end else if (run_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = run_i && (cnt_q == LAST);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle RV32 ALU controller: base op decode plus sequencing of the
// iterative M-extension engine. Divide support is built only with ALU_CTRL_DIV_EN.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALU_Op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic [3:0]      op,
    output logic            is_md,
    output logic            stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result,
    output logic            md_illegal
);

    md_state_e       state_q, state_d;
    logic [2:0]      funct3_q;
    logic            negQuot_q;
    logic [XLEN-1:0] result_q, fixRes;
    logic            accept, signA, signB, engDone, engRun;
    logic [XLEN-1:0] magA, magB, engHi, engLo, negHi;
`ifdef ALU_CTRL_DIV_EN
    logic            negRem_q, divZero_q, divZero;
`else
    logic            illegal_q;
`endif

    assign is_md = (ALU_Op == ALUOP_R) && (funct7 == F7_MULDIV);

    always_comb begin
        op = OP_ADD;
        case (ALU_Op)
            ALUOP_MEM: op = OP_ADD;
            ALUOP_BR:  op = OP_SUB;
            default: begin
                if (!is_md) begin
                    case (funct3)
                        3'd0: op = (ALU_Op == ALUOP_R && funct7[5]) ? OP_SUB : OP_ADD;
                        3'd1: op = OP_SLL;
                        3'd2: op = OP_SLT;
                        3'd3: op = OP_SLTU;
                        3'd4: op = OP_XOR;
                        3'd5: op = funct7[5] ? OP_SRA : OP_SRL;
                        3'd6: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
        endcase
    end

    assign accept = (state_q == S_IDLE) && in_valid && is_md && !flush;
    assign signA  = signedRs1(funct3) && rs1[XLEN-1];
    assign signB  = signedRs2(funct3) && rs2[XLEN-1];
    assign magA   = signA ? -rs1 : rs1;
    assign magB   = signB ? -rs2 : rs2;
    assign engRun = (state_q == S_MUL) || (state_q == S_DIV);
`ifdef ALU_CTRL_DIV_EN
    assign divZero = funct3[2] && (rs2 == '0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_CTRL_DIV_EN
                    if (!funct3[2])   state_d = S_MUL;
                    else if (divZero) state_d = S_DONE;
                    else              state_d = S_DIV;
`else
                    state_d = funct3[2] ? S_DONE : S_MUL;
`endif
                end
            end
            S_MUL, S_DIV: if (engDone) state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    muldiv_iter #(.XLEN(XLEN)) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ALU_CTRL_DIV_EN
        .isDiv_i (funct3[2]),
`endif
        .start_i (accept),
        .run_i   (engRun),
        .a_i     (magA),
        .b_i     (magB),
        .done_o  (engDone),
        .hi_o    (engHi),
        .lo_o    (engLo)
    );

    // Upper half of the negated 2*XLEN product: borrow only propagates when lo is zero.
    assign negHi = ~engHi + {{(XLEN-1){1'b0}}, (engLo == '0)};

    always_comb begin
        fixRes = '0;
        case (funct3_q)
            F3_MUL:                      fixRes = engLo;
            F3_MULH, F3_MULHSU, F3_MULHU: fixRes = negQuot_q ? negHi : engHi;
`ifdef ALU_CTRL_DIV_EN
            F3_DIV, F3_DIVU:
                fixRes = divZero_q ? '1 : (negQuot_q ? -engLo : engLo);
            F3_REM, F3_REMU:
                fixRes = divZero_q ? (negRem_q ? -engLo : engLo)
                                   : (negRem_q ? -engHi : engHi);
`endif
            default:                     fixRes = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            negQuot_q <= 1'b0;
            result_q  <= '0;
`ifdef ALU_CTRL_DIV_EN
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
`else
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q  <= funct3;
                negQuot_q <= signA ^ signB;
`ifdef ALU_CTRL_DIV_EN
                negRem_q  <= signA;
                divZero_q <= divZero;
`else
                illegal_q <= funct3[2];
`endif
            end
            if (state_q == S_DONE) result_q <= fixRes;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign stall     = (state_q != S_IDLE) || accept;
    assign md_valid  = (state_q == S_DONE);
    assign md_result = md_valid ? fixRes : result_q;
`ifdef ALU_CTRL_DIV_EN
    assign md_illegal = 1'b0;
`else
    assign md_illegal = md_valid && illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: decode table, random decode and M ops
// against an arithmetic reference model, plus flush/reset corner sequences.
module tb_alu_ctrl_mc;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ALU_Op = 2'b00;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready, is_md, stall, md_valid, md_illegal;
    logic [3:0]  op;
    logic [31:0] md_result;

    int vecCount = 0;
    int missCount = 0;

    alu_ctrl_mc #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALU_Op     (ALU_Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .op         (op),
        .is_md      (is_md),
        .stall      (stall),
        .md_valid   (md_valid),
        .md_result  (md_result),
        .md_illegal (md_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aluOp;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] expOp;
        logic       expMd;
    } decVec_t;

    typedef struct {
        logic [31:0] result;
        logic        illegal;
        int          latency;
    } mdExp_t;

    // Base-ISA mnemonic rules mapped to the 4-bit ALU op code.
    function automatic logic [3:0] refOp(logic [1:0] a, logic [2:0] f3, logic [6:0] f7);
        if (a == 2'b00) return 4'b0010;
        if (a == 2'b01) return 4'b0110;
        if (a == 2'b10 && f7 == 7'b0000001) return 4'b0010;
        case (f3)
            3'd0: return (a == 2'b10 && f7[5]) ? 4'b0110 : 4'b0010;
            3'd1: return 4'b0011;
            3'd2: return 4'b0111;
            3'd3: return 4'b1010;
            3'd4: return 4'b0101;
            3'd5: return f7[5] ? 4'b1001 : 4'b1000;
            3'd6: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // RISC-V M semantics computed with 64-bit integer arithmetic.
    function automatic mdExp_t refMd(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        mdExp_t e;
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.result = '0;
        e.illegal = 1'b0;
        e.latency = XLEN + 1;
        case (f3)
            3'd0: begin p = ua * ub; e.result = p[31:0]; end
            3'd1: begin p = sa * sb; e.result = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); e.result = p[63:32]; end
            3'd3: begin p = ua * ub; e.result = p[63:32]; end
            default: begin
`ifdef ALU_CTRL_DIV_EN
                if (b == 32'd0) begin
                    e.latency = 1;
                    e.result = (f3 == 3'd4 || f3 == 3'd5) ? 32'hFFFF_FFFF : a;
                end else if (f3 == 3'd4) begin
                    e.result = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
                end else if (f3 == 3'd5) begin
                    e.result = a / b;
                end else if (f3 == 3'd6) begin
                    e.result = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
                end else begin
                    e.result = a % b;
                end
`else
                e.illegal = 1'b1;
                e.latency = 1;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issues one M op from a post-edge point and follows it to the cycle after md_valid.
    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        mdExp_t e;
        int cycle;
        bit stallOk;
        e = refMd(f3, a, b);
        ALU_Op = 2'b10; funct7 = 7'b0000001; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
        #1;
        checkOutput({name, " in_ready c0"}, in_ready, 1);
        checkOutput({name, " stall c0"}, stall, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; ALU_Op = 2'b00; funct7 = 7'd0;
        cycle = 1;
        stallOk = 1'b1;
        while (!md_valid && cycle < 100) begin
            if (!stall) stallOk = 1'b0;
            @(posedge clk); #1;
            cycle++;
        end
        stallOk = stallOk && stall;
        checkOutput({name, " latency"}, cycle, e.latency);
        checkOutput({name, " result"}, md_result, e.result);
        checkOutput({name, " illegal"}, md_illegal, e.illegal);
        checkOutput({name, " stall held"}, stallOk, 1);
        @(posedge clk); #1;
        checkOutput({name, " ready after"}, {in_ready, stall, md_valid}, 3'b100);
        checkOutput({name, " result held"}, md_result, e.result);
    endtask

    decVec_t vecs[17];
    logic [31:0] prevRes;
    bit sawValid, heldOk;
    logic [2:0] rf3;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{2'b00, 3'd0, 7'h00, 4'b0010, 1'b0};
        vecs[1]  = '{2'b01, 3'd3, 7'h20, 4'b0110, 1'b0};
        vecs[2]  = '{2'b10, 3'd0, 7'h00, 4'b0010, 1'b0};
        vecs[3]  = '{2'b10, 3'd0, 7'h20, 4'b0110, 1'b0};
        vecs[4]  = '{2'b10, 3'd1, 7'h00, 4'b0011, 1'b0};
        vecs[5]  = '{2'b10, 3'd2, 7'h00, 4'b0111, 1'b0};
        vecs[6]  = '{2'b10, 3'd3, 7'h00, 4'b1010, 1'b0};
        vecs[7]  = '{2'b10, 3'd4, 7'h00, 4'b0101, 1'b0};
        vecs[8]  = '{2'b10, 3'd5, 7'h00, 4'b1000, 1'b0};
        vecs[9]  = '{2'b10, 3'd5, 7'h20, 4'b1001, 1'b0};
        vecs[10] = '{2'b10, 3'd6, 7'h00, 4'b0001, 1'b0};
        vecs[11] = '{2'b10, 3'd7, 7'h00, 4'b0000, 1'b0};
        vecs[12] = '{2'b11, 3'd0, 7'h20, 4'b0010, 1'b0};
        vecs[13] = '{2'b11, 3'd5, 7'h20, 4'b1001, 1'b0};
        vecs[14] = '{2'b11, 3'd2, 7'h7F, 4'b0111, 1'b0};
        vecs[15] = '{2'b10, 3'd7, 7'h01, 4'b0010, 1'b1};
        vecs[16] = '{2'b11, 3'd1, 7'h01, 4'b0011, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs", {in_ready, stall, md_valid, md_illegal}, 4'b1000);
        checkOutput("reset result", md_result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            ALU_Op = vecs[i].aluOp; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
            #1;
            checkOutput($sformatf("decode op v%0d", i), op, vecs[i].expOp);
            checkOutput($sformatf("decode is_md v%0d", i), is_md, vecs[i].expMd);
        end

        for (int i = 0; i < 30; i++) begin
            ALU_Op = 2'($urandom_range(0, 3));
            funct3 = 3'($urandom_range(0, 7));
            funct7 = ($urandom_range(0, 3) == 0) ? 7'h01 : 7'($urandom);
            #1;
            checkOutput($sformatf("rand op %0d", i), op, refOp(ALU_Op, funct3, funct7));
            checkOutput($sformatf("rand is_md %0d", i), is_md, (ALU_Op == 2'b10 && funct7 == 7'h01));
        end

        @(posedge clk); #1;
        ALU_Op = 2'b10; funct3 = 3'd0; funct7 = 7'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("non-md ignored", {in_ready, stall}, 2'b10);
        ALU_Op = 2'b10; funct7 = 7'h01; flush = 1'b1;
        #1;
        checkOutput("flush idle stall", stall, 0);
        @(posedge clk); #1;
        checkOutput("flush idle no accept", {in_ready, stall}, 2'b10);
        flush = 1'b0; in_valid = 1'b0; ALU_Op = 2'b00; funct7 = 7'h00;

        applyStimulus("MULH -1x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        applyStimulus("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("DIVU 5/0", 3'd5, 32'd5, 32'd0);
        applyStimulus("REMU 5/0", 3'd7, 32'd5, 32'd0);
        applyStimulus("MULHSU", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        applyStimulus("MUL 3x4", 3'd0, 32'd3, 32'd4);

        prevRes = md_result;
        ALU_Op = 2'b10; funct7 = 7'h01; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ALU_Op = 2'b00; funct7 = 7'h00;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush ready c11", {in_ready, stall}, 2'b10);
        sawValid = 1'b0; heldOk = 1'b1;
        repeat (40) begin
            if (md_valid) sawValid = 1'b1;
            if (md_result !== prevRes) heldOk = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("flush no valid", sawValid, 0);
        checkOutput("flush result held", heldOk, 1);

`ifdef ALU_CTRL_DIV_EN
        ALU_Op = 2'b10; funct7 = 7'h01; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
`else
        ALU_Op = 2'b10; funct7 = 7'h01; funct3 = 3'd0; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0; ALU_Op = 2'b00; funct7 = 7'h00;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("pre-reset stall", stall, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset flags", {in_ready, stall, md_valid, md_illegal}, 4'b1000);
        checkOutput("mid reset result", md_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("MUL after reset", 3'd0, 32'd6, 32'd7);

        for (int i = 0; i < 16; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            applyStimulus($sformatf("rand md %0d", i), rf3, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
